// File: rtl/dpe_tx_retry_pkg.sv
// Shared definitions for the PD transmit-retry controller.
package dpe_tx_retry_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_CRC = 2'd2
    } state_t;

    // nRetryCount default
    localparam int N_RETRY_COUNT = 2;
    localparam int MSG_ID_W      = 3;

endpackage

// File: rtl/dpe_tx_retry.sv
// Transmit-retry controller: launches a message, arms CRCReceiveTimer and
// retries on timeout or PHY error, reporting one result per transfer.
module dpe_tx_retry
    import dpe_tx_retry_pkg::*;
#(
    parameter int N_RETRY = N_RETRY_COUNT,
    parameter int RETRY_W = 2,
    parameter int ID_W    = MSG_ID_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tx_req,
    input  logic               soft_reset,
    output logic               phy_tx_start,
    output logic [ID_W-1:0]    phy_tx_msg_id,
    input  logic               phy_tx_done,
    input  logic               phy_tx_err,
    input  logic               rx_goodcrc,
    input  logic [ID_W-1:0]    rx_goodcrc_id,
    input  logic               rx_msg,
    output logic               timer_start,
    output logic               timer_stop,
    input  logic               timer_timeout,
    output logic               tx_busy,
    output logic               tx_success,
    output logic               tx_fail,
    output logic               tx_discard,
    output logic [RETRY_W-1:0] retry_cnt
);

    state_t state;
    logic   can_retry;
    logic   crc_match;

    assign can_retry = (retry_cnt < RETRY_W'(N_RETRY));
    assign crc_match = rx_goodcrc && (rx_goodcrc_id == phy_tx_msg_id);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            phy_tx_start  <= 1'b0;
            phy_tx_msg_id <= '0;
            timer_start   <= 1'b0;
            timer_stop    <= 1'b0;
            tx_busy       <= 1'b0;
            tx_success    <= 1'b0;
            tx_fail       <= 1'b0;
            tx_discard    <= 1'b0;
            retry_cnt     <= '0;
        end else begin
            phy_tx_start <= 1'b0;
            timer_start  <= 1'b0;
            timer_stop   <= 1'b0;
            tx_success   <= 1'b0;
            tx_fail      <= 1'b0;
            tx_discard   <= 1'b0;
            if (soft_reset) begin
                // Stop is harmless when the timer is idle, so always issue it.
                tx_discard    <= (state != IDLE);
                timer_stop    <= 1'b1;
                state         <= IDLE;
                tx_busy       <= 1'b0;
                phy_tx_msg_id <= '0;
                retry_cnt     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (tx_req) begin
                            state        <= SEND;
                            tx_busy      <= 1'b1;
                            retry_cnt    <= '0;
                            phy_tx_start <= 1'b1;
                        end
                    end
                    SEND: begin
                        if (rx_msg) begin
                            tx_discard <= 1'b1;
                            timer_stop <= 1'b1;
                            state      <= IDLE;
                            tx_busy    <= 1'b0;
                        end else if (phy_tx_err) begin
                            if (can_retry) begin
                                retry_cnt    <= retry_cnt + 1'b1;
                                phy_tx_start <= 1'b1;
                            end else begin
                                tx_fail       <= 1'b1;
                                phy_tx_msg_id <= phy_tx_msg_id + 1'b1;
                                state         <= IDLE;
                                tx_busy       <= 1'b0;
                            end
                        end else if (phy_tx_done) begin
                            state       <= WAIT_CRC;
                            timer_start <= 1'b1;
                        end
                    end
                    WAIT_CRC: begin
                        if (rx_msg) begin
                            tx_discard <= 1'b1;
                            timer_stop <= 1'b1;
                            state      <= IDLE;
                            tx_busy    <= 1'b0;
                        end else if (crc_match) begin
                            tx_success    <= 1'b1;
                            timer_stop    <= 1'b1;
                            phy_tx_msg_id <= phy_tx_msg_id + 1'b1;
                            state         <= IDLE;
                            tx_busy       <= 1'b0;
                        end else if (timer_timeout) begin
                            // Stopping on every exit keeps timeout low on re-entry.
                            timer_stop <= 1'b1;
                            if (can_retry) begin
                                retry_cnt    <= retry_cnt + 1'b1;
                                phy_tx_start <= 1'b1;
                                state        <= SEND;
                            end else begin
                                tx_fail       <= 1'b1;
                                phy_tx_msg_id <= phy_tx_msg_id + 1'b1;
                                state         <= IDLE;
                                tx_busy       <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dpe_tx_retry.sv
// Self-checking bench for dpe_tx_retry: transfer-level reference model,
// directed scenarios with literal expectations, then random traffic.
module tb_dpe_tx_retry;

    localparam int N_RETRY = 2;
    localparam int RETRY_W = 2;
    localparam int ID_W    = 3;

    localparam int F_REQ = 1, F_SR = 2, F_DONE = 4, F_ERR = 8, F_GC = 16, F_RM = 32, F_TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_req = 0, soft_reset = 0, phy_tx_done = 0, phy_tx_err = 0;
    logic rx_goodcrc = 0, rx_msg = 0, timer_timeout = 0;
    logic [ID_W-1:0] rx_goodcrc_id = '0;
    logic phy_tx_start, timer_start, timer_stop, tx_busy, tx_success, tx_fail, tx_discard;
    logic [ID_W-1:0] phy_tx_msg_id;
    logic [RETRY_W-1:0] retry_cnt;

    always #5 clk = ~clk;

    dpe_tx_retry #(.N_RETRY(N_RETRY), .RETRY_W(RETRY_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .tx_req(tx_req), .soft_reset(soft_reset),
        .phy_tx_start(phy_tx_start), .phy_tx_msg_id(phy_tx_msg_id),
        .phy_tx_done(phy_tx_done), .phy_tx_err(phy_tx_err),
        .rx_goodcrc(rx_goodcrc), .rx_goodcrc_id(rx_goodcrc_id), .rx_msg(rx_msg),
        .timer_start(timer_start), .timer_stop(timer_stop), .timer_timeout(timer_timeout),
        .tx_busy(tx_busy), .tx_success(tx_success), .tx_fail(tx_fail),
        .tx_discard(tx_discard), .retry_cnt(retry_cnt)
    );

    logic [11:0] dut_vec;
    assign dut_vec = {phy_tx_start, phy_tx_msg_id, timer_start, timer_stop, tx_busy,
                      tx_success, tx_fail, tx_discard, retry_cnt};

    // Reference model: a transfer is either absent, being transmitted, or awaiting its ack.
    typedef enum {PH_NONE, PH_XMIT, PH_ACK} phase_t;
    typedef enum {EV_NONE, EV_SOFT, EV_REQ, EV_ABORT, EV_SENT, EV_ACK, EV_MISS} ev_t;

    phase_t m_phase;
    int     m_id;       // next MessageID, 0..2^ID_W-1
    int     m_attempt;  // 1-based attempt number of current/last transfer
    bit     e_start, e_tstart, e_tstop, e_succ, e_fail, e_disc;

    int n_pass = 0, n_total = 0;
    int c_start, c_succ, c_fail, c_disc, c_tstop;

    function automatic logic [11:0] exp_vec();
        return {e_start, 3'(m_id), e_tstart, e_tstop, (m_phase != PH_NONE),
                e_succ, e_fail, e_disc, 2'(m_attempt - 1)};
    endfunction

    function automatic void model_reset();
        m_phase = PH_NONE; m_id = 0; m_attempt = 1;
        {e_start, e_tstart, e_tstop, e_succ, e_fail, e_disc} = '0;
    endfunction

    function automatic ev_t pick(int f, logic [ID_W-1:0] gid);
        if (f & F_SR) return EV_SOFT;
        case (m_phase)
            PH_NONE: return (f & F_REQ) ? EV_REQ : EV_NONE;
            PH_XMIT: begin
                if (f & F_RM)   return EV_ABORT;
                if (f & F_ERR)  return EV_MISS;
                if (f & F_DONE) return EV_SENT;
                return EV_NONE;
            end
            default: begin
                if (f & F_RM) return EV_ABORT;
                if ((f & F_GC) && int'(gid) == m_id) return EV_ACK;
                if (f & F_TO) return EV_MISS;
                return EV_NONE;
            end
        endcase
    endfunction

    function automatic void model_apply(int f, logic [ID_W-1:0] gid);
        ev_t ev = pick(f, gid);
        {e_start, e_tstart, e_tstop, e_succ, e_fail, e_disc} = '0;
        case (ev)
            EV_SOFT:  begin e_disc = (m_phase != PH_NONE); e_tstop = 1; m_phase = PH_NONE; m_id = 0; m_attempt = 1; end
            EV_REQ:   begin m_phase = PH_XMIT; m_attempt = 1; e_start = 1; end
            EV_ABORT: begin e_disc = 1; e_tstop = 1; m_phase = PH_NONE; end
            EV_SENT:  begin m_phase = PH_ACK; e_tstart = 1; end
            EV_ACK:   begin e_succ = 1; e_tstop = 1; m_id = (m_id + 1) % (1 << ID_W); m_phase = PH_NONE; end
            EV_MISS: begin
                e_tstop = (m_phase == PH_ACK);
                if (m_attempt < N_RETRY + 1) begin
                    m_attempt++; e_start = 1; m_phase = PH_XMIT;
                end else begin
                    e_fail = 1; m_id = (m_id + 1) % (1 << ID_W); m_phase = PH_NONE;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic clr();
        c_start = 0; c_succ = 0; c_fail = 0; c_disc = 0; c_tstop = 0;
    endtask

    task automatic step(input int f, input logic [ID_W-1:0] gid);
        tx_req = f[0]; soft_reset = f[1]; phy_tx_done = f[2]; phy_tx_err = f[3];
        rx_goodcrc = f[4]; rx_msg = f[5]; timer_timeout = f[6]; rx_goodcrc_id = gid;
        model_apply(f, gid);
        @(posedge clk); #1;
        check("cycle", int'(dut_vec), int'(exp_vec()));
        check("one_result", int'($countones({tx_success, tx_fail, tx_discard}) <= 1), 1);
        c_start += int'(phy_tx_start); c_succ += int'(tx_success); c_fail += int'(tx_fail);
        c_disc += int'(tx_discard); c_tstop += int'(timer_stop);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_outputs", int'(dut_vec), 0);

        // single clean transfer
        clr();
        step(F_REQ, 0); step(0, 0); step(F_DONE, 0); step(0, 0); step(F_GC, 3'd0);
        check("t1_id", int'(phy_tx_msg_id), 1);
        check("t1_retry", int'(retry_cnt), 0);
        check("t1_starts", c_start, 1);
        check("t1_success", c_succ, 1);
        check("t1_tstop", c_tstop, 1);

        // timeout then success
        clr();
        step(F_REQ, 0); step(F_DONE, 0); step(F_TO, 0);
        check("t2_id_on_retry", int'(phy_tx_msg_id), 1);
        step(F_DONE, 0); step(F_GC, 3'd1);
        check("t2_starts", c_start, 2);
        check("t2_success", c_succ, 1);
        check("t2_retry", int'(retry_cnt), 1);
        check("t2_id", int'(phy_tx_msg_id), 2);

        // three timeouts -> fail
        clr();
        step(F_REQ, 0);
        for (int i = 0; i < 3; i++) begin step(F_DONE, 0); step(F_TO, 0); end
        check("t3_starts", c_start, 3);
        check("t3_fail", c_fail, 1);
        check("t3_retry", int'(retry_cnt), 2);
        check("t3_id", int'(phy_tx_msg_id), 3);

        // wrong-ID GoodCRC ignored, then rx_msg discards
        clr();
        step(F_REQ, 0); step(F_DONE, 0); step(F_GC, 3'd0); step(F_TO, 0);
        step(F_DONE, 0); step(F_RM, 0);
        check("t4_starts", c_start, 2);
        check("t4_discard", c_disc, 1);
        check("t4_success", c_succ, 0);
        check("t4_id", int'(phy_tx_msg_id), 3);

        // ack beats timeout; soft reset discards
        clr();
        step(F_REQ, 0); step(F_DONE, 0); step(F_GC | F_TO, 3'd3);
        check("t5_success", c_succ, 1);
        check("t5_id", int'(phy_tx_msg_id), 4);
        clr();
        step(F_REQ, 0); step(F_DONE, 0); step(F_SR | F_GC, 3'd4);
        check("t5_sr_discard", c_disc, 1);
        check("t5_sr_success", c_succ, 0);
        check("t5_sr_id", int'(phy_tx_msg_id), 0);
        clr();
        step(F_SR | F_REQ, 0); step(0, 0);
        check("t5_req_dropped", int'(tx_busy), 0);
        check("t5_idle_sr_disc", c_disc, 0);

        // MessageID wrap
        for (int k = 0; k < 8; k++) begin
            step(F_REQ, 0); step(F_DONE, 0); step(F_GC, 3'(k));
            check("t6_wrap_id", int'(phy_tx_msg_id), (k + 1) % 8);
        end

        // asynchronous reset mid-WAIT_CRC
        step(F_REQ, 0); step(F_DONE, 0);
        tx_req = 0; phy_tx_done = 0;
        #2 rst_n = 1'b0;
        #1 check("async_reset", int'(dut_vec), 0);
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            int f;
            logic [ID_W-1:0] gid;
            f = 0;
            if ($urandom_range(99) < 30) f |= F_REQ;
            if ($urandom_range(99) < 2)  f |= F_SR;
            if ($urandom_range(99) < 30) f |= F_DONE;
            if ($urandom_range(99) < 8)  f |= F_ERR;
            if ($urandom_range(99) < 20) f |= F_GC;
            if ($urandom_range(99) < 4)  f |= F_RM;
            if ($urandom_range(99) < 15) f |= F_TO;
            gid = $urandom_range(1) ? 3'(m_id) : 3'($urandom_range(7));
            step(f, gid);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dpe_tx_retry.md
Name: dpe_tx_retry

Overview:
- Transmit-retry controller for the PD protocol layer. It sits between the policy engine and the PHY transmitter.
- It launches a message with the current MessageID, then arms an external dpe_timer instance as CRCReceiveTimer. It waits for a matching GoodCRC.
- On timeout or PHY error it retries up to N_RETRY times, then reports exactly one result to the policy engine: success, fail, or discard.
- It is the direct upstream driver of dpe_timer's start/stop and the sole consumer of its timeout.

Parameters:
- N_RETRY, 2, retries after the first attempt (total attempts = N_RETRY+1).
- RETRY_W, 2, width of the retry counter; must hold N_RETRY.
- ID_W, 3, MessageID width; wraps modulo 2^ID_W.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- tx_req  input  1  pulse: send one message; accepted only in IDLE, ignored otherwise
- soft_reset  input  1  pulse: abort any transfer, clear MessageID
- phy_tx_start  output  1  registered 1-cycle pulse: PHY begins transmission
- phy_tx_msg_id  output  ID_W  MessageID for the current attempt; stable while busy
- phy_tx_done  input  1  pulse: PHY finished sending the frame
- phy_tx_err  input  1  pulse: PHY aborted the frame (collision or bus error)
- rx_goodcrc  input  1  pulse: GoodCRC received
- rx_goodcrc_id  input  ID_W  MessageID carried by the GoodCRC; valid with rx_goodcrc
- rx_msg  input  1  pulse: non-GoodCRC message received
- timer_start  output  1  registered pulse to dpe_timer.start
- timer_stop  output  1  registered pulse to dpe_timer.stop
- timer_timeout  input  1  dpe_timer.timeout (level)
- tx_busy  output  1  high in every state other than IDLE
- tx_success  output  1  1-cycle result pulse
- tx_fail  output  1  1-cycle result pulse
- tx_discard  output  1  1-cycle result pulse
- retry_cnt  output  RETRY_W  retries used by the current or last transfer

Behaviour:
- Reset: state IDLE. All outputs 0. MessageID 0, retry_cnt 0.
- All outputs are registered. No combinational path from any input to any output.
- State IDLE, on tx_req:
  - go to SEND, clear retry_cnt, pulse phy_tx_start on the next cycle.
- State SEND: wait for phy_tx_done or phy_tx_err.
  - phy_tx_done: go to WAIT_CRC and pulse timer_start.
  - phy_tx_err: counts as a failed attempt (see retry rule).
  - If both arrive in the same cycle, phy_tx_err wins.
- State WAIT_CRC, evaluated each cycle:
  - rx_goodcrc with rx_goodcrc_id == MessageID: pulse tx_success and timer_stop, increment MessageID, go to IDLE.
  - rx_goodcrc with a mismatched ID: ignored.
  - timer_timeout: failed attempt; pulse timer_stop.
- Retry rule:
  - If retry_cnt < N_RETRY: increment retry_cnt, go to SEND, re-pulse phy_tx_start with the same MessageID.
  - Otherwise: pulse tx_fail, increment MessageID, go to IDLE.
- rx_msg in SEND or WAIT_CRC:
  - pulse tx_discard and timer_stop, go to IDLE.
  - MessageID is unchanged.
- Same-cycle priority: soft_reset > rx_msg > matching rx_goodcrc > timer_timeout / phy_tx_err.
- soft_reset in any state:
  - go to IDLE, MessageID = 0, retry_cnt = 0, pulse timer_stop.
  - If busy, also pulse tx_discard.
  - A tx_req in the same cycle is dropped.
- Timer contract:
  - timer_stop is issued on every exit from WAIT_CRC, so timer_timeout is low when WAIT_CRC is next entered.
  - timer_timeout is never sampled outside WAIT_CRC.
  - dpe_timer VALUE must be >= 2.
- Per transfer: exactly one of tx_success / tx_fail / tx_discard pulses, and never two in the same cycle.
- MessageID wraps from 2^ID_W-1 to 0.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, SEND, WAIT_CRC
  - default retry count constant (nRetryCount = 2)
  - MessageID width
- No sub-module. dpe_timer is instantiated by the parent, not inside this block.

Test Plan:
- tx_req, then phy_tx_done, then rx_goodcrc id=0 -> single phy_tx_start, tx_success once, MessageID=1, retry_cnt=0, timer_stop pulsed.
- tx_req; first attempt times out; second attempt gets matching GoodCRC -> 2 phy_tx_start pulses with phy_tx_msg_id unchanged, tx_success, retry_cnt=1.
- Three consecutive timeouts (N_RETRY=2) -> 3 phy_tx_start pulses, then tx_fail, MessageID incremented, retry_cnt=2.
- GoodCRC with a wrong ID, then timeout; separately, rx_msg during WAIT_CRC -> wrong ID ignored and retry taken; rx_msg gives tx_discard with MessageID unchanged.
- Matching rx_goodcrc and timer_timeout in the same cycle -> tx_success; soft_reset in the same cycle -> tx_discard, MessageID=0.
- Eight successful transfers -> MessageID wraps 7->0; rst_n asserted mid-WAIT_CRC -> all outputs 0 immediately.
